uart_cmd_link: RTL and testbench
================================

Name: uart_cmd_link

Overview:
- Parametrised successor to the acquisition-control UART: one full-duplex 8N1 link between the host (Python) and the acquisition top level.
- RX parser decodes framed commands: 'A' configures an acquisition, 'S' is a debug strobe.
- TX serialiser returns a response of parametrised byte count.
- Adds glitch rejection, framing-error and inter-byte-timeout recovery, unknown-opcode rejection and a TX busy handshake.

Parameters:
- CLK, 60, system clock in MHz.
- BAUD, 921600, line rate in bit/s.
- TX_BYTES, 2, response length in bytes (1..8).
- THRESH_W, 13, threshold width.
- SAMPLE_W, 22, samples_before and samples_after width.
- TIMEOUT_BITS, 32, idle bit-times allowed between bytes of one packet.

Ports:
- clk_PSRAM  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- uart_rx  in  1  RX line, idle high.
- uart_tx  out  1  TX line, idle high.
- send_uart  in  1  one-cycle request to transmit send_msg.
- send_msg  in  8*TX_BYTES  response; most significant byte sent first.
- tx_busy  out  1  high from the accepted request until the last stop bit ends.
- trigger  out  8  trigger type from the 'A' packet.
- threshold  out  THRESH_W  trigger threshold.
- samples_after  out  SAMPLE_W  samples to capture after the trigger.
- samples_before  out  SAMPLE_W  samples to capture before the trigger.
- flag_acq  out  1  one-cycle pulse when a valid 'A' packet has been latched.
- flag_debug  out  1  one-cycle pulse on 'S'.
- flag_end_tx  out  1  one-cycle pulse when transmission completes.
- err_frame  out  1  one-cycle pulse on a stop-bit error.
- err_timeout  out  1  one-cycle pulse on an inter-byte timeout.
- err_opcode  out  1  one-cycle pulse on an unknown first byte.

Behaviour:
- Bit timing:
  - DELAY_FRAMES = (CLK*1_000_000)/BAUD, integer division.
  - HALF = DELAY_FRAMES/2.
  - Counters are sized with $clog2(DELAY_FRAMES*TIMEOUT_BITS+1).
- Reset (rst_n=0 at a clk edge):
  - uart_tx=1; tx_busy=0.
  - All flags and error pulses = 0.
  - trigger, threshold, samples_after, samples_before = 0.
  - RX, TX and parser FSMs go to IDLE; the byte counter is cleared.
  - Reset mid-frame aborts at once; no partial byte is delivered.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE→START when uart_rx=0.
  - START: at count HALF, re-sample. If uart_rx=1, treat as a glitch and return to IDLE with no error. Otherwise go to DATA.
  - DATA: sample every DELAY_FRAMES; LSB first; 8 bits.
  - STOP: sample at the bit centre. If 1, byte_valid pulses for 1 cycle. If 0, pulse err_frame, discard the byte, reset the parser, and go to IDLE. In both cases the FSM returns to IDLE at the stop-bit centre.
- Parser, driven by byte_valid:
  - Byte 0 = 0x53: flag_debug pulses the cycle after byte_valid; counter stays 0.
  - Byte 0 = 0x41: store bytes 1..9.
  - On the 10th byte, all fields update on the same edge, and flag_acq pulses one cycle later. Mapping:
    - trigger=b1.
    - threshold={b2[THRESH_W-9:0],b3}.
    - samples_after={b4[SAMPLE_W-17:0],b5,b6}.
    - samples_before={b7[SAMPLE_W-17:0],b8,b9}.
  - Fields hold their value until the next complete packet.
  - Any other byte 0: err_opcode pulses; counter stays 0.
  - 'S' (0x53) mid-packet is data, not a command.
  - Counter nonzero and idle time ≥ TIMEOUT_BITS*DELAY_FRAMES: err_timeout pulses, counter=0, fields untouched.
  - The timeout counter restarts on every byte_valid.
- TX FSM, states IDLE, START, DATA, STOP:
  - send_uart is accepted only when tx_busy=0; otherwise it is ignored and not queued.
  - On accept, latch send_msg, set tx_busy=1, and drive uart_tx=0 the next cycle.
  - Each bit lasts exactly DELAY_FRAMES cycles.
  - Bytes are sent MSB-byte first, LSB bit first, with one stop bit each and no gap between bytes.
  - After the last stop bit: tx_busy=0 and flag_end_tx=1 for one cycle, on the same edge.
  - A new send_uart is accepted in that same cycle.
- RX and TX are fully independent; simultaneous activity is legal.
- If byte_valid coincides with the timeout, byte_valid wins and the timeout is not flagged.

Decomposition:
- Package uart_link_pkg: opcode constants OP_ACQ=8'h41 and OP_DBG=8'h53, ACQ_LEN=10, RX/TX state encodings, and a DELAY_FRAMES function.
- Sub-module uart_rx_core: bit-level receiver with outputs byte_valid, byte_data and frame_err. It is instantiated once.
- The parser and TX FSM stay in uart_cmd_link.

Test Plan (CLK=60, BAUD=921600, DELAY_FRAMES=65):
- Send 41 54 00 FF 00 10 00 00 00 80 → trigger=0x54, threshold=0x00FF, samples_after=0x001000, samples_before=0x000080; flag_acq is a single 1-cycle pulse.
- send_uart with send_msg=16'hA55A → line carries 0xA5 then 0x5A, 650 cycles per byte; flag_end_tx pulses at cycle 1300±1; a send_uart while busy is ignored.
- 20-cycle low glitch on uart_rx → no byte_valid and no error; a following 0x53 gives flag_debug.
- Byte with stop bit held low → err_frame pulses; parser reset; the following valid 'A' packet decodes correctly.
- Send 41 01 02, then idle for 32*65 cycles → err_timeout pulses; fields keep their previous values.
- Assert rst_n=0 mid-TX and mid-RX → uart_tx=1 and all outputs return to reset values on the next edge; next 0x58 → err_opcode pulses.

Source files
------------

// File: rtl/uart_link_pkg.sv
// uart_link_pkg
//   Shared definitions for the host command link: opcode bytes, the length
//   of an acquisition packet, the RX/TX state encodings and the bit-period
//   helper.
//   No ports (package).
package uart_link_pkg;

  localparam logic [7:0] OP_ACQ  = 8'h41;  // 'A' : configure acquisition
  localparam logic [7:0] OP_DBG  = 8'h53;  // 'S' : debug strobe
  localparam int         ACQ_LEN = 10;     // opcode + 9 payload bytes

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Clock cycles per bit, truncated.
  function automatic int delay_frames(input int clk_mhz, input int baud);
    return (clk_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_cmd_link_rx_core.sv
// uart_rx_core
//   Bit-level 8N1 receiver. The line is brought into the clock domain with
//   a two-flop synchroniser; a start bit is confirmed at its centre so that
//   short low glitches are dropped silently.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   rx         in   serial line, idle high
//   byte_valid out  one-cycle pulse, byte_data holds the received byte
//   byte_data  out  last good byte
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   state      out  current FSM state (observability)
module uart_rx_core
  import uart_link_pkg::*;
#(
  parameter int DELAY_FRAMES = 65,
  parameter int CNT_W        = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output rx_state_t  state
);

  localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(DELAY_FRAMES / 2);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(DELAY_FRAMES - 1);

  logic [1:0]       sync;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync       <= 2'b11;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], rx};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          // Line back high at the start-bit centre: a glitch, not a frame.
          if (cnt == HALF_C) begin
            cnt   <= '0;
            state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};  // LSB arrives first
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_link.sv
// uart_cmd_link
//   Full-duplex 8N1 link between the host and the acquisition top level.
//   RX bytes are parsed into 'A' (acquisition config) and 'S' (debug strobe)
//   commands; the TX side serialises a TX_BYTES response, MSB byte first.
// Ports:
//   clk_PSRAM                   in   system clock
//   rst_n                       in   synchronous active-low reset
//   uart_rx / uart_tx           in/out serial lines, idle high
//   send_uart, send_msg         in   transmit request and payload
//   tx_busy                     out  transmitter occupied
//   trigger, threshold,
//   samples_after,
//   samples_before              out  fields of the last complete 'A' packet
//   flag_acq, flag_debug,
//   flag_end_tx                 out  one-cycle event pulses
//   err_frame, err_timeout,
//   err_opcode                  out  one-cycle error pulses
//
// TX handshake: send_uart is a request that is taken only in a cycle where
// tx_busy is low; the payload is captured on that edge and tx_busy rises on
// it. A request while tx_busy is high is dropped, never queued. tx_busy falls
// on the same edge that raises flag_end_tx, and a request in that cycle is
// taken.
module uart_cmd_link
  import uart_link_pkg::*;
#(
  parameter int CLK          = 60,
  parameter int BAUD         = 921600,
  parameter int TX_BYTES     = 2,
  parameter int THRESH_W     = 13,
  parameter int SAMPLE_W     = 22,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                  clk_PSRAM,
  input  logic                  rst_n,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  input  logic                  send_uart,
  input  logic [8*TX_BYTES-1:0] send_msg,
  output logic                  tx_busy,
  output logic [7:0]            trigger,
  output logic [THRESH_W-1:0]   threshold,
  output logic [SAMPLE_W-1:0]   samples_after,
  output logic [SAMPLE_W-1:0]   samples_before,
  output logic                  flag_acq,
  output logic                  flag_debug,
  output logic                  flag_end_tx,
  output logic                  err_frame,
  output logic                  err_timeout,
  output logic                  err_opcode
);

  localparam int DELAY = delay_frames(CLK, BAUD);
  localparam int CNT_W = $clog2(DELAY * TIMEOUT_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] TOUT_END  = CNT_W'(DELAY * TIMEOUT_BITS - 1);
  localparam logic [3:0]       LAST_IDX  = 4'(ACQ_LEN - 1);
  localparam logic [2:0]       LAST_BYTE = 3'(TX_BYTES - 1);

  // ---------------------------------------------------------------- RX
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;
  rx_state_t  rx_state;

  uart_rx_core #(
    .DELAY_FRAMES (DELAY),
    .CNT_W        (CNT_W)
  ) u_rx (
    .clk        (clk_PSRAM),
    .rst_n      (rst_n),
    .rx         (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err),
    .state      (rx_state)
  );

  // ------------------------------------------------------------ parser
  // Payload is staged per field so all four outputs commit on one edge.
  logic [3:0]          byte_cnt;
  logic [CNT_W-1:0]    idle_cnt;
  logic                acq_pend;
  logic [7:0]          stg_trig;
  logic [THRESH_W-1:0] stg_thr;
  logic [SAMPLE_W-1:0] stg_sa;
  logic [SAMPLE_W-9:0] stg_sb;

  always_ff @(posedge clk_PSRAM) begin
    if (!rst_n) begin
      byte_cnt       <= '0;
      idle_cnt       <= '0;
      acq_pend       <= 1'b0;
      stg_trig       <= '0;
      stg_thr        <= '0;
      stg_sa         <= '0;
      stg_sb         <= '0;
      trigger        <= '0;
      threshold      <= '0;
      samples_after  <= '0;
      samples_before <= '0;
      flag_acq       <= 1'b0;
      flag_debug     <= 1'b0;
      err_frame      <= 1'b0;
      err_timeout    <= 1'b0;
      err_opcode     <= 1'b0;
    end else begin
      flag_debug  <= 1'b0;
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
      err_frame   <= frame_err;
      flag_acq    <= acq_pend;
      acq_pend    <= 1'b0;
      if (frame_err) begin
        byte_cnt <= '0;
        idle_cnt <= '0;
      end else if (byte_valid) begin
        // A byte landing on the timeout cycle wins over the timeout.
        idle_cnt <= '0;
        if (byte_cnt == 4'd0) begin
          if (byte_data == OP_ACQ)      byte_cnt   <= 4'd1;
          else if (byte_data == OP_DBG) flag_debug <= 1'b1;
          else                          err_opcode <= 1'b1;
        end else begin
          byte_cnt <= (byte_cnt == LAST_IDX) ? 4'd0 : byte_cnt + 4'd1;
          case (byte_cnt)
            4'd1: stg_trig                 <= byte_data;
            4'd2: stg_thr[THRESH_W-1:8]    <= byte_data[THRESH_W-9:0];
            4'd3: stg_thr[7:0]             <= byte_data;
            4'd4: stg_sa[SAMPLE_W-1:16]    <= byte_data[SAMPLE_W-17:0];
            4'd5: stg_sa[15:8]             <= byte_data;
            4'd6: stg_sa[7:0]              <= byte_data;
            4'd7: stg_sb[SAMPLE_W-9:8]     <= byte_data[SAMPLE_W-17:0];
            4'd8: stg_sb[7:0]              <= byte_data;
            4'd9: begin
              trigger        <= stg_trig;
              threshold      <= stg_thr;
              samples_after  <= stg_sa;
              samples_before <= {stg_sb, byte_data};
              acq_pend       <= 1'b1;
            end
            default: ;
          endcase
        end
      end else if (byte_cnt != 4'd0) begin
        if (idle_cnt == TOUT_END) begin
          err_timeout <= 1'b1;
          byte_cnt    <= '0;
          idle_cnt    <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- TX
  tx_state_t             tx_state;
  logic [8*TX_BYTES-1:0] tx_msg;
  logic [CNT_W-1:0]      tx_cnt;
  logic [2:0]            tx_bit;
  logic [2:0]            tx_byte_idx;
  logic [7:0]            tx_cur;

  // The byte on the line is always the top byte; tx_msg shifts up per byte.
  assign tx_cur = tx_msg[8*TX_BYTES-1 -: 8];

  always_ff @(posedge clk_PSRAM) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_msg      <= '0;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_byte_idx <= '0;
      uart_tx     <= 1'b1;
      tx_busy     <= 1'b0;
      flag_end_tx <= 1'b0;
    end else begin
      flag_end_tx <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          tx_cnt      <= '0;
          tx_bit      <= '0;
          tx_byte_idx <= '0;
          uart_tx     <= 1'b1;
          if (send_uart && !tx_busy) begin
            tx_msg   <= send_msg;
            tx_busy  <= 1'b1;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_tx  <= tx_cur[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              uart_tx <= tx_cur[tx_bit + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_byte_idx == LAST_BYTE) begin
              tx_busy     <= 1'b0;
              flag_end_tx <= 1'b1;
              tx_state    <= TX_IDLE;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              tx_byte_idx <= tx_byte_idx + 3'd1;
              tx_msg      <= tx_msg << 8;
              uart_tx     <= 1'b0;
              tx_state    <= TX_START;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_link.sv
// tb_uart_cmd_link
//   Directed + randomised bench for uart_cmd_link. RX traffic is modelled as
//   a byte stream fed to a packet-level reference; TX traffic is decoded off
//   the line at bit centres and compared with an expected byte queue.
module tb_uart_cmd_link;

  localparam int CLK          = 60;
  localparam int BAUD         = 921600;
  localparam int TX_BYTES     = 2;
  localparam int THRESH_W     = 13;
  localparam int SAMPLE_W     = 22;
  localparam int TIMEOUT_BITS = 32;
  localparam int DF           = (CLK * 1000000) / BAUD;  // 65
  localparam int FRAME        = 10 * DF;
  localparam int MW           = 8 * TX_BYTES;

  // ------------------------------------------------ clock / reset block
  logic                clk_PSRAM = 1'b0;
  logic                rst_n     = 1'b0;
  logic                uart_rx   = 1'b1;
  logic                send_uart = 1'b0;
  logic [MW-1:0]       send_msg  = '0;
  logic                uart_tx, tx_busy;
  logic [7:0]          trigger;
  logic [THRESH_W-1:0] threshold;
  logic [SAMPLE_W-1:0] samples_after, samples_before;
  logic                flag_acq, flag_debug, flag_end_tx;
  logic                err_frame, err_timeout, err_opcode;

  always #5 clk_PSRAM = ~clk_PSRAM;

  uart_cmd_link #(
    .CLK(CLK), .BAUD(BAUD), .TX_BYTES(TX_BYTES), .THRESH_W(THRESH_W),
    .SAMPLE_W(SAMPLE_W), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk_PSRAM(clk_PSRAM), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .send_uart(send_uart), .send_msg(send_msg), .tx_busy(tx_busy),
    .trigger(trigger), .threshold(threshold), .samples_after(samples_after),
    .samples_before(samples_before), .flag_acq(flag_acq), .flag_debug(flag_debug),
    .flag_end_tx(flag_end_tx), .err_frame(err_frame), .err_timeout(err_timeout),
    .err_opcode(err_opcode)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: event counts and the longest run of any flag.
  int cnt_acq = 0, cnt_dbg = 0, cnt_end = 0, cnt_frame = 0, cnt_tout = 0, cnt_op = 0;
  int run[6];
  int max_run = 0;
  logic [5:0] fl;
  always @(negedge clk_PSRAM) begin
    fl = {flag_acq, flag_debug, flag_end_tx, err_frame, err_timeout, err_opcode};
    if (flag_acq)    cnt_acq++;
    if (flag_debug)  cnt_dbg++;
    if (flag_end_tx) cnt_end++;
    if (err_frame)   cnt_frame++;
    if (err_timeout) cnt_tout++;
    if (err_opcode)  cnt_op++;
    for (int i = 0; i < 6; i++) begin
      run[i] = fl[i] ? run[i] + 1 : 0;
      if (run[i] > max_run) max_run = run[i];
    end
  end

  // --------------------------------------------------- reference model
  logic [7:0]          pkt_q[$];
  logic [7:0]          exp_trig = '0;
  logic [THRESH_W-1:0] exp_thr  = '0;
  logic [SAMPLE_W-1:0] exp_sa   = '0, exp_sb = '0;
  int exp_acq = 0, exp_dbg = 0, exp_op = 0, exp_frame = 0, exp_tout = 0, exp_end = 0;
  logic [7:0] exp_q[$];  // TX bytes expected on the line

  task automatic model_byte(input logic [7:0] b);
    if (pkt_q.size() == 0) begin
      if (b == 8'h41)      pkt_q.push_back(b);
      else if (b == 8'h53) exp_dbg++;
      else                 exp_op++;
    end else begin
      pkt_q.push_back(b);
      if (pkt_q.size() == 10) begin
        exp_trig = pkt_q[1];
        exp_thr  = THRESH_W'((int'(pkt_q[2]) % (1 << (THRESH_W - 8))) * 256 + int'(pkt_q[3]));
        exp_sa   = SAMPLE_W'((int'(pkt_q[4]) % (1 << (SAMPLE_W - 16))) * 65536 +
                             int'(pkt_q[5]) * 256 + int'(pkt_q[6]));
        exp_sb   = SAMPLE_W'((int'(pkt_q[7]) % (1 << (SAMPLE_W - 16))) * 65536 +
                             int'(pkt_q[8]) * 256 + int'(pkt_q[9]));
        exp_acq++;
        pkt_q.delete();
      end
    end
  endtask

  task automatic check_fields(input string tag);
    check({tag, ".trigger"},   32'(trigger),        32'(exp_trig));
    check({tag, ".threshold"}, 32'(threshold),      32'(exp_thr));
    check({tag, ".s_after"},   32'(samples_after),  32'(exp_sa));
    check({tag, ".s_before"},  32'(samples_before), 32'(exp_sb));
  endtask

  task automatic check_counts(input string tag);
    check({tag, ".acq"},   cnt_acq,   exp_acq);
    check({tag, ".dbg"},   cnt_dbg,   exp_dbg);
    check({tag, ".op"},    cnt_op,    exp_op);
    check({tag, ".frame"}, cnt_frame, exp_frame);
    check({tag, ".tout"},  cnt_tout,  exp_tout);
  endtask

  // ------------------------------------------------------ driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_PSRAM);
  endtask

  task automatic rx_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    cyc(DF);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cyc(DF);
    end
    if (bad_stop) begin
      uart_rx = 1'b0;
      cyc(48);
      uart_rx = 1'b1;
      cyc(2 * DF);
    end else begin
      uart_rx = 1'b1;
      cyc(DF);
    end
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    foreach (seq[i]) begin
      rx_byte(seq[i], 1'b0);
      model_byte(seq[i]);
      cyc($urandom_range(0, 20));
    end
    cyc(5);
  endtask

  logic samp [1:1400];

  // Caller has raised send_uart with msg at the previous negedge.
  task automatic tx_observe(input logic [MW-1:0] msg, input bit poke_busy,
                            input bit chain, input logic [MW-1:0] next_msg);
    int end_k;
    end_k = -1;
    for (int j = TX_BYTES - 1; j >= 0; j--) exp_q.push_back(msg[8*j +: 8]);
    exp_end++;
    for (int k = 1; k <= FRAME * TX_BYTES + 10; k++) begin
      @(negedge clk_PSRAM);
      if (k == 1) send_uart = 1'b0;
      samp[k] = uart_tx;
      if (k == FRAME / 2) check("tx_busy_mid", 32'(tx_busy), 32'd1);
      if (poke_busy && k == 100) begin
        send_msg  = ~msg;
        send_uart = 1'b1;
      end
      if (poke_busy && k == 101) send_uart = 1'b0;
      if (flag_end_tx) begin
        end_k = k;
        check("tx_busy_at_end", 32'(tx_busy), 32'd0);
        if (chain) begin
          send_msg  = next_msg;
          send_uart = 1'b1;
        end
        break;
      end
    end
    check("tx_end_cycle_window",
          32'((end_k >= FRAME * TX_BYTES - 1) && (end_k <= FRAME * TX_BYTES + 1)), 32'd1);
    for (int j = 0; j < TX_BYTES; j++) begin
      logic [7:0] got;
      int base;
      base = j * FRAME + DF / 2 + 1;
      check("tx_start_bit", 32'(samp[base]), 32'd0);
      for (int i = 0; i < 8; i++) got[i] = samp[base + (i + 1) * DF];
      check("tx_stop_bit", 32'(samp[base + 9 * DF]), 32'd1);
      check("tx_byte", 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  // -------------------------------------------------------- stimulus
  initial begin
    logic [7:0] seq[$];
    logic [7:0] op;
    logic [MW-1:0] m1, m2;
    int busy_cyc;

    cyc(4);
    check("rst.uart_tx", 32'(uart_tx), 32'd1);
    check("rst.tx_busy", 32'(tx_busy), 32'd0);
    check("rst.flags", 32'({flag_acq, flag_debug, flag_end_tx, err_frame, err_timeout, err_opcode}), 32'd0);
    check_fields("rst");
    rst_n = 1'b1;
    cyc(10);

    // Directed acquisition packet
    seq = {8'h41, 8'h54, 8'h00, 8'hFF, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80};
    send_seq(seq);
    check("dir.trigger",   32'(trigger),        32'h54);
    check("dir.threshold", 32'(threshold),      32'h00FF);
    check("dir.s_after",   32'(samples_after),  32'h001000);
    check("dir.s_before",  32'(samples_before), 32'h000080);
    check_counts("dir");

    // Directed response with a request while busy
    send_msg = 16'hA55A; send_uart = 1'b1;
    tx_observe(16'hA55A, 1'b1, 1'b0, '0);
    busy_cyc = 0;
    repeat (200) begin
      @(negedge clk_PSRAM);
      if (tx_busy || !uart_tx) busy_cyc++;
    end
    check("tx_ignored_busy_req", busy_cyc, 0);
    check("tx_end_pulses", cnt_end, exp_end);

    // Start-bit glitch, then a debug strobe
    uart_rx = 1'b0; cyc(20); uart_rx = 1'b1; cyc(200);
    check_counts("glitch");
    seq = {8'h53};
    send_seq(seq);
    check_counts("dbg");

    // Framing error mid-packet, then a clean random packet
    rx_byte(8'h41, 1'b0); model_byte(8'h41);
    rx_byte(8'h12, 1'b1);
    exp_frame++; pkt_q.delete();
    cyc(10);
    check_counts("frame");
    seq = {8'h41};
    for (int i = 0; i < 9; i++) seq.push_back(8'($urandom_range(0, 255)));
    send_seq(seq);
    check_fields("after_frame");
    check_counts("after_frame");

    // Inter-byte timeout: nothing before the limit, one pulse after it
    seq = {8'h41, 8'h01, 8'h02};
    send_seq(seq);
    cyc(TIMEOUT_BITS * DF - 250);
    check("tout_not_early", cnt_tout, exp_tout);
    cyc(300);
    exp_tout++; pkt_q.delete();
    check_counts("tout");
    check_fields("tout");

    // Random commands, with concurrent TX traffic on one packet
    for (int it = 0; it < 4; it++) begin
      seq = {8'h41};
      for (int i = 0; i < 9; i++) seq.push_back(8'($urandom_range(0, 255)));
      if (it == 0) seq[2] = 8'h53;  // 'S' inside a packet is payload
      do op = 8'($urandom_range(0, 255)); while (op == 8'h41 || op == 8'h53);
      seq.push_front(op);
      if (it[0]) seq.push_front(8'h53);
      if (it == 1) begin
        m1 = MW'($urandom); m2 = MW'($urandom);
        fork
          send_seq(seq);
          begin
            send_msg = m1; send_uart = 1'b1;
            tx_observe(m1, 1'b0, 1'b1, m2);
            tx_observe(m2, 1'b0, 1'b0, '0);
          end
        join
      end else begin
        send_seq(seq);
      end
      check_fields($sformatf("rand%0d", it));
      check_counts($sformatf("rand%0d", it));
    end
    check("tx_end_pulses2", cnt_end, exp_end);

    // Reset in the middle of a TX frame and an RX frame
    send_msg = 16'h3C96; send_uart = 1'b1; uart_rx = 1'b0;
    cyc(1); send_uart = 1'b0;
    cyc(300);
    check("pre_rst.tx_busy", 32'(tx_busy), 32'd1);
    rst_n = 1'b0; uart_rx = 1'b1;
    @(posedge clk_PSRAM); #1;
    check("mid_rst.uart_tx", 32'(uart_tx), 32'd1);
    check("mid_rst.tx_busy", 32'(tx_busy), 32'd0);
    check("mid_rst.flags", 32'({flag_acq, flag_debug, flag_end_tx, err_frame, err_timeout, err_opcode}), 32'd0);
    exp_trig = '0; exp_thr = '0; exp_sa = '0; exp_sb = '0; pkt_q.delete();
    check_fields("mid_rst");
    @(negedge clk_PSRAM); rst_n = 1'b1;
    cyc(20);
    seq = {8'h58};
    send_seq(seq);
    check_counts("post_rst");
    check("post_rst.end_pulses", cnt_end, exp_end);
    check("pulse_width_max", max_run, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
